filter_pair_buffer: RTL and testbench

FILTER_PAIR_BUFFER -- requirements
Module: filter_pair_buffer

---
 rtl/filter_pair_buffer.sv | 116 +++++++++++
 tb/tb_filter_pair_buffer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_pair_buffer.sv
// filter_pair_buffer: show-ahead FIFO between the pair filter and the force evaluator.
// Optional statistics counters are built when PAIR_BUF_STATS_EN is defined.
`default_nettype none

module filter_pair_buffer #(
  parameter int DEPTH                = 16,
  parameter int AF_THRESH            = DEPTH - 4,
  parameter int PARTICLE_ID_WIDTH    = 9,
  parameter int POS_PKT_STRUCT_WIDTH = 54,
  parameter int NODE_ID_WIDTH        = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_pair_valid,
  input  logic [PARTICLE_ID_WIDTH-1:0]    i_home_parid,
  input  logic [POS_PKT_STRUCT_WIDTH-1:0] i_nb_pos,
  input  logic [NODE_ID_WIDTH-1:0]        i_nb_node_id,
  input  logic                            i_nb_from_home_cell,
  input  logic                            i_pair_ready,
  output logic                            o_pair_valid,
  output logic [PARTICLE_ID_WIDTH-1:0]    o_home_parid,
  output logic [POS_PKT_STRUCT_WIDTH-1:0] o_nb_pos,
  output logic [NODE_ID_WIDTH-1:0]        o_nb_node_id,
  output logic                            o_nb_from_home_cell,
  output logic                            o_almost_full,
  output logic                            o_overflow,
  output logic [31:0]                     o_pair_count,
  output logic [$clog2(DEPTH+1)-1:0]      o_max_occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = PARTICLE_ID_WIDTH + POS_PKT_STRUCT_WIDTH + NODE_ID_WIDTH + 1;
  localparam logic [CW-1:0] FULL_C   = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C     = CW'(AF_THRESH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic          af_q;
  logic          ovf_q, ovf_d;
  logic          push;
  logic          pop;

  assign o_pair_valid = (count_q != '0);
  assign pop          = o_pair_valid & i_pair_ready;
  // A full buffer still accepts when the head leaves in the same cycle.
  assign push         = i_pair_valid & ((count_q != FULL_C) | pop);

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (push) wr_d = wr_q + PTR_ONE;
    if (pop)  rd_d = rd_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    if (i_pair_valid && !push) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      af_q    <= (count_d >= AF_C);
      ovf_q   <= ovf_d;
    end
  end

  // Storage needs no reset: only entries below count are ever presented.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {i_home_parid, i_nb_pos, i_nb_node_id, i_nb_from_home_cell};
  end

  assign {o_home_parid, o_nb_pos, o_nb_node_id, o_nb_from_home_cell} = mem_q[rd_q];
  assign o_almost_full = af_q;
  assign o_overflow    = ovf_q;

`ifdef PAIR_BUF_STATS_EN
  logic [31:0]   pcount_q;
  logic [CW-1:0] maxocc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcount_q <= '0;
      maxocc_q <= '0;
    end else begin
      if (push) pcount_q <= pcount_q + 32'd1;
      if (count_d > maxocc_q) maxocc_q <= count_d;
    end
  end

  assign o_pair_count    = pcount_q;
  assign o_max_occupancy = maxocc_q;
`else
  assign o_pair_count    = '0;
  assign o_max_occupancy = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_filter_pair_buffer.sv
// Randomized self-checking bench for filter_pair_buffer against a queue-based model.
`default_nettype none

module tb_filter_pair_buffer;

  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int PIDW  = 8;
  localparam int POSW  = 16;
  localparam int NIDW  = 4;
  localparam int EW    = PIDW + POSW + NIDW + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            i_pair_valid = 1'b0;
  logic [PIDW-1:0] i_home_parid = '0;
  logic [POSW-1:0] i_nb_pos = '0;
  logic [NIDW-1:0] i_nb_node_id = '0;
  logic            i_nb_from_home_cell = 1'b0;
  logic            i_pair_ready = 1'b0;
  logic            o_pair_valid;
  logic [PIDW-1:0] o_home_parid;
  logic [POSW-1:0] o_nb_pos;
  logic [NIDW-1:0] o_nb_node_id;
  logic            o_nb_from_home_cell;
  logic            o_almost_full;
  logic            o_overflow;
  logic [31:0]     o_pair_count;
  logic [4:0]      o_max_occupancy;
  logic [EW-1:0]   w_head;

  filter_pair_buffer #(
    .DEPTH(DEPTH), .AF_THRESH(AF), .PARTICLE_ID_WIDTH(PIDW),
    .POS_PKT_STRUCT_WIDTH(POSW), .NODE_ID_WIDTH(NIDW)
  ) dut (
    .clk(clk), .rst(rst),
    .i_pair_valid(i_pair_valid), .i_home_parid(i_home_parid), .i_nb_pos(i_nb_pos),
    .i_nb_node_id(i_nb_node_id), .i_nb_from_home_cell(i_nb_from_home_cell),
    .i_pair_ready(i_pair_ready),
    .o_pair_valid(o_pair_valid), .o_home_parid(o_home_parid), .o_nb_pos(o_nb_pos),
    .o_nb_node_id(o_nb_node_id), .o_nb_from_home_cell(o_nb_from_home_cell),
    .o_almost_full(o_almost_full), .o_overflow(o_overflow),
    .o_pair_count(o_pair_count), .o_max_occupancy(o_max_occupancy)
  );

  assign w_head = {o_home_parid, o_nb_pos, o_nb_node_id, o_nb_from_home_cell};

  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference model: pair queue plus flags, advanced once per rising edge.
  logic [EW-1:0] m_q[$];
  bit            m_ovf = 0;
  bit            m_af  = 0;
  bit [31:0]     m_cnt = 0;
  int            m_max = 0;
  logic [EW-1:0] last_pop;

  function automatic logic [EW-1:0] rnd_pair();
    return EW'($urandom());
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_ovf = 0; m_af = 0; m_cnt = 0; m_max = 0;
  endtask

  task automatic step(input logic v, input logic [EW-1:0] d, input logic r);
    bit mpop, mpush;
    @(negedge clk);
    i_pair_valid = v;
    {i_home_parid, i_nb_pos, i_nb_node_id, i_nb_from_home_cell} = d;
    i_pair_ready = r;
    @(posedge clk);
    mpop  = (m_q.size() != 0) && r;
    mpush = v && ((m_q.size() < DEPTH) || mpop);
    if (v && !mpush) m_ovf = 1;
    if (mpop) last_pop = m_q.pop_front();
    if (mpush) begin m_q.push_back(d); m_cnt = m_cnt + 1; end
    m_af = (m_q.size() >= AF);
    if (m_q.size() > m_max) m_max = m_q.size();
    #1;
  endtask

  task automatic assert_reset();
    @(posedge clk); #2;
    i_pair_valid = 1'b0; i_pair_ready = 1'b0;
    rst = 1'b0;
    model_clear();
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk); #2;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    assert_reset();
    checks++; if (o_pair_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", o_pair_valid); end
    checks++; if (o_almost_full !== 1'b0) begin errors++; $display("FAIL reset_af got=%b exp=0", o_almost_full); end
    checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", o_overflow); end
    checks++; if (o_pair_count !== 32'd0 || o_max_occupancy !== 5'd0) begin
      errors++; $display("FAIL reset_stats got=%0d/%0d exp=0/0", o_pair_count, o_max_occupancy); end
    release_reset();
    checks++; if (o_pair_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid got=%b exp=0", o_pair_valid); end
  endtask

  task automatic test_single();
    logic [EW-1:0] d;
    d = rnd_pair();
    checks++; if (o_pair_valid !== 1'b0) begin errors++; $display("FAIL single_pre got=%b exp=0", o_pair_valid); end
    step(1'b1, d, 1'b1);
    checks++; if (o_pair_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", o_pair_valid); end
    checks++; if (w_head !== d) begin errors++; $display("FAIL single_data got=%h exp=%h", w_head, d); end
    step(1'b0, '0, 1'b1);
    checks++; if (o_pair_valid !== 1'b0) begin errors++; $display("FAIL single_empty got=%b exp=0", o_pair_valid); end
  endtask

  task automatic test_almost_full();
    for (int i = 1; i <= AF; i++) begin
      step(1'b1, rnd_pair(), 1'b0);
      checks++; if (o_almost_full !== (i >= AF)) begin
        errors++; $display("FAIL af_rise push=%0d got=%b exp=%b", i, o_almost_full, (i >= AF)); end
    end
    step(1'b0, '0, 1'b1);
    checks++; if (o_almost_full !== 1'b0) begin errors++; $display("FAIL af_clear got=%b exp=0", o_almost_full); end
    checks++; if (w_head !== m_q[0]) begin errors++; $display("FAIL af_head got=%h exp=%h", w_head, m_q[0]); end
  endtask

  task automatic test_overflow();
    logic [EW-1:0] first;
    first = m_q[0];
    while (m_q.size() < DEPTH) step(1'b1, rnd_pair(), 1'b0);
    checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got=%b exp=0", o_overflow); end
    step(1'b1, rnd_pair(), 1'b0);
    checks++; if (o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", o_overflow); end
    checks++; if (w_head !== first) begin errors++; $display("FAIL ovf_head got=%h exp=%h", w_head, first); end
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    checks++; if (o_overflow !== 1'b1 || o_almost_full !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky got=%b/%b exp=1/1", o_overflow, o_almost_full); end
  endtask

  task automatic test_full_push_pop();
    logic [EW-1:0] first, second, d;
    first = m_q[0]; second = m_q[1]; d = rnd_pair();
    step(1'b1, d, 1'b1);
    checks++; if (last_pop !== first || w_head !== second) begin
      errors++; $display("FAIL fpp_pop got=%h exp=%h", w_head, second); end
    checks++; if (m_q.size() != DEPTH || m_q[DEPTH-1] !== d) begin
      errors++; $display("FAIL fpp_model size=%0d exp=%0d", m_q.size(), DEPTH); end
    // Drain down to 7 entries, checking order on every pop.
    while (m_q.size() > 7) begin
      step(1'b0, '0, 1'b1);
      checks++; if (w_head !== m_q[0]) begin errors++; $display("FAIL fpp_order got=%h exp=%h", w_head, m_q[0]); end
    end
    checks++; if (o_almost_full !== 1'b0 || o_overflow !== 1'b1) begin
      errors++; $display("FAIL fpp_flags got=%b/%b exp=0/1", o_almost_full, o_overflow); end
  endtask

  task automatic test_reset_mid();
    logic [EW-1:0] d;
    assert_reset();
    checks++; if (o_pair_valid !== 1'b0 || o_almost_full !== 1'b0 || o_overflow !== 1'b0) begin
      errors++; $display("FAIL midrst got=%b%b%b exp=000", o_pair_valid, o_almost_full, o_overflow); end
    release_reset();
    d = rnd_pair();
    step(1'b1, d, 1'b0);
    checks++; if (o_pair_valid !== 1'b1 || w_head !== d) begin
      errors++; $display("FAIL midrst_push got=%b/%h exp=1/%h", o_pair_valid, w_head, d); end
    step(1'b0, '0, 1'b1);
    checks++; if (o_pair_valid !== 1'b0) begin errors++; $display("FAIL midrst_count got=%b exp=0", o_pair_valid); end
  endtask

  task automatic test_stream();
    bit [31:0] base;
    int        cyc;
    assert_reset();
    release_reset();
    base = m_cnt;
    cyc = 0;
    while ((m_cnt - base) < 40 && cyc < 2000) begin
      step(1'($urandom_range(0, 1)), rnd_pair(), 1'($urandom_range(0, 1)));
      cyc++;
      checks++; if (o_pair_valid !== (m_q.size() != 0)) begin
        errors++; $display("FAIL stream_valid got=%b exp=%b", o_pair_valid, (m_q.size() != 0)); end
      if (m_q.size() != 0) begin
        checks++; if (w_head !== m_q[0]) begin errors++; $display("FAIL stream_order got=%h exp=%h", w_head, m_q[0]); end
      end
    end
    checks++; if ((m_cnt - base) < 40) begin errors++; $display("FAIL stream_timeout got=%0d exp=40", m_cnt - base); end
    cyc = 0;
    while (m_q.size() != 0 && cyc < 100) begin
      step(1'b0, '0, 1'b1);
      cyc++;
      if (m_q.size() != 0) begin
        checks++; if (w_head !== m_q[0]) begin errors++; $display("FAIL drain_order got=%h exp=%h", w_head, m_q[0]); end
      end
    end
    checks++; if (o_pair_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got=%b exp=0", o_pair_valid); end
    checks++; if (o_overflow !== m_ovf) begin errors++; $display("FAIL stream_ovf got=%b exp=%b", o_overflow, m_ovf); end
  endtask

  task automatic test_stats();
    assert_reset();
    release_reset();
    for (int i = 0; i < 9; i++) step(1'b1, rnd_pair(), 1'b0);
    for (int i = 0; i < 11; i++) step(1'b1, rnd_pair(), 1'b1);
    while (m_q.size() != 0) step(1'b0, '0, 1'b1);
`ifdef PAIR_BUF_STATS_EN
    checks++; if (o_pair_count !== m_cnt || o_pair_count !== 32'd20) begin
      errors++; $display("FAIL stats_count got=%0d exp=%0d", o_pair_count, m_cnt); end
    checks++; if (o_max_occupancy !== 5'(m_max) || o_max_occupancy !== 5'd9) begin
      errors++; $display("FAIL stats_max got=%0d exp=%0d", o_max_occupancy, m_max); end
`else
    checks++; if (o_pair_count !== 32'd0) begin errors++; $display("FAIL stats_count got=%0d exp=0", o_pair_count); end
    checks++; if (o_max_occupancy !== 5'd0) begin errors++; $display("FAIL stats_max got=%0d exp=0", o_max_occupancy); end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_almost_full();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    test_stream();
    test_stats();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
